// File: rtl/wb_ibus_dbus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic master port between iBus and dBus.
// One transfer per grant, one idle cycle between grants; optional grant timeout via WB_ARB_TIMEOUT_EN.
module wb_ibus_dbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] iBusWishbone_ADR,
    input  logic [3:0]  iBusWishbone_SEL,
    input  logic        iBusWishbone_CYC,
    input  logic        iBusWishbone_STB,
    output logic [31:0] iBusWishbone_DAT_MISO,
    output logic        iBusWishbone_ACK,
    output logic        iBusWishbone_ERR,
    input  logic [29:0] dBusWishbone_ADR,
    input  logic [31:0] dBusWishbone_DAT_MOSI,
    input  logic [3:0]  dBusWishbone_SEL,
    input  logic        dBusWishbone_CYC,
    input  logic        dBusWishbone_STB,
    input  logic        dBusWishbone_WE,
    output logic [31:0] dBusWishbone_DAT_MISO,
    output logic        dBusWishbone_ACK,
    output logic        dBusWishbone_ERR,
    output logic [29:0] busWishbone_ADR,
    output logic [31:0] busWishbone_DAT_MOSI,
    output logic [3:0]  busWishbone_SEL,
    output logic        busWishbone_CYC,
    output logic        busWishbone_STB,
    output logic        busWishbone_WE,
    input  logic [31:0] busWishbone_DAT_MISO,
    input  logic        busWishbone_ACK,
    input  logic        busWishbone_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be within 2..65535");
        end
    endgenerate

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   req_i, req_d, resp, timeout;

    assign req_i = iBusWishbone_CYC & iBusWishbone_STB;
    assign req_d = dBusWishbone_CYC & dBusWishbone_STB;
    assign resp  = busWishbone_ACK | busWishbone_ERR;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // Counter sits at zero while idle, so every grant starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!resp) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q != IDLE) && !resp && (cnt_q == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // On contention the master that was not served last wins.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (req_d && (!req_i || !last_d_q)) begin
                    state_d  = GNT_D;
                    last_d_d = 1'b1;
                end else if (req_i) begin
                    state_d  = GNT_I;
                    last_d_d = 1'b0;
                end
            end
            GNT_I: if (resp || !req_i || timeout) state_d = IDLE;
            GNT_D: if (resp || !req_d || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign iBusWishbone_DAT_MISO = busWishbone_DAT_MISO;
    assign dBusWishbone_DAT_MISO = busWishbone_DAT_MISO;

    // Everything except read data is masked while reset is held low.
    always_comb begin
        busWishbone_ADR      = '0;
        busWishbone_DAT_MOSI = '0;
        busWishbone_SEL      = '0;
        busWishbone_CYC      = 1'b0;
        busWishbone_STB      = 1'b0;
        busWishbone_WE       = 1'b0;
        iBusWishbone_ACK     = 1'b0;
        iBusWishbone_ERR     = 1'b0;
        dBusWishbone_ACK     = 1'b0;
        dBusWishbone_ERR     = 1'b0;
        if (reset) begin
            case (state_q)
                GNT_I: begin
                    busWishbone_ADR  = iBusWishbone_ADR;
                    busWishbone_SEL  = iBusWishbone_SEL;
                    busWishbone_CYC  = iBusWishbone_CYC & ~timeout;
                    busWishbone_STB  = iBusWishbone_STB & ~timeout;
                    iBusWishbone_ACK = busWishbone_ACK;
                    iBusWishbone_ERR = busWishbone_ERR | timeout;
                end
                GNT_D: begin
                    busWishbone_ADR      = dBusWishbone_ADR;
                    busWishbone_DAT_MOSI = dBusWishbone_DAT_MOSI;
                    busWishbone_SEL      = dBusWishbone_SEL;
                    busWishbone_CYC      = dBusWishbone_CYC & ~timeout;
                    busWishbone_STB      = dBusWishbone_STB & ~timeout;
                    busWishbone_WE       = dBusWishbone_WE;
                    dBusWishbone_ACK     = busWishbone_ACK;
                    dBusWishbone_ERR     = busWishbone_ERR | timeout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wb_ibus_dbus_arbiter.md
Name: wb_ibus_dbus_arbiter

Overview:
- Shares one Wishbone classic master port between the CPU's instruction-fetch bus (iBus) and load/store bus (dBus), for SoCs that expose a single bus port.
- Sits between the CPU wrapper's iBus/dBus Wishbone master interfaces and the interconnect.
- Round-robin grant, one transfer per grant, registered grant decision.

Parameters:
- TIMEOUT_CYCLES, 255, cycles a granted transfer may wait for ACK/ERR before forced ERR (only with WB_ARB_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- iBusWishbone_ADR  in  30  fetch word address [31:2]
- iBusWishbone_SEL  in  4  fetch byte select
- iBusWishbone_CYC  in  1  fetch cycle request
- iBusWishbone_STB  in  1  fetch strobe
- iBusWishbone_DAT_MISO  out  32  read data to fetch master
- iBusWishbone_ACK  out  1  fetch acknowledge
- iBusWishbone_ERR  out  1  fetch error
- dBusWishbone_ADR  in  30  data word address [31:2]
- dBusWishbone_DAT_MOSI  in  32  store data
- dBusWishbone_SEL  in  4  data byte select
- dBusWishbone_CYC  in  1  data cycle request
- dBusWishbone_STB  in  1  data strobe
- dBusWishbone_WE  in  1  data write enable
- dBusWishbone_DAT_MISO  out  32  read data to data master
- dBusWishbone_ACK  out  1  data acknowledge
- dBusWishbone_ERR  out  1  data error
- busWishbone_ADR  out  30  shared word address
- busWishbone_DAT_MOSI  out  32  shared write data
- busWishbone_SEL  out  4  shared byte select
- busWishbone_CYC  out  1  shared cycle
- busWishbone_STB  out  1  shared strobe
- busWishbone_WE  out  1  shared write enable
- busWishbone_DAT_MISO  in  32  shared read data
- busWishbone_ACK  in  1  shared acknowledge
- busWishbone_ERR  in  1  shared error

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset=0 resets on the next rising edge of clk).
- State: IDLE, GNT_I, GNT_D; register last_d (1 = dBus granted last).
- Reset: state=IDLE, last_d=0. With reset low: busWishbone_CYC/STB/WE=0, ADR/DAT_MOSI/SEL=0, all ACK/ERR=0. Reset mid-transfer abandons the transfer: shared CYC drops the cycle after the reset edge, and no ACK is forwarded.
- Request: req_x = xBusWishbone_CYC & xBusWishbone_STB.
- IDLE: only req_i -> GNT_I; only req_d -> GNT_D; both -> grant the master not granted last (last_d=0 -> D, last_d=1 -> I); none -> stay. last_d updates on grant.
- Latency: request first seen in IDLE at edge n; shared CYC/STB are asserted from cycle n+1. The outputs are combinational from state.
- GNT_x: busWishbone_ADR/SEL/DAT_MOSI/CYC/STB mux from master x. WE = dBusWishbone_WE in GNT_D, 0 in GNT_I. In IDLE all shared outputs are 0.
- Response routing: DAT_MISO is broadcast to both masters. xBusWishbone_ACK = busWishbone_ACK & (state==GNT_x); same rule for ERR. The non-granted master never sees ACK/ERR.
- Release: in GNT_x, ACK|ERR or a deasserted req_x -> IDLE next edge. There is one idle cycle between consecutive transfers. The other requester, if pending, wins the next IDLE.
- Simultaneous: ACK and the granted master dropping CYC in the same cycle are treated as a normal completion. The pending master waits in IDLE one cycle, then is granted.
- ERR is forwarded identically to ACK and ends the grant.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to GNT_x and increments each GNT cycle without ACK/ERR.
  - When count == TIMEOUT_CYCLES-1 with no ACK/ERR: drive xBusWishbone_ERR=1 for that cycle, force busWishbone_CYC/STB=0 in the same cycle, and go to IDLE.
  - A late slave ACK arriving after this is ignored.
- Undefined: no counter; a grant holds indefinitely until ACK/ERR or the master drops its request.

Test Plan:
- Reset low 2 cycles during an active GNT_D -> busWishbone_CYC=0 the cycle after the reset edge; dBus ACK never asserted; state IDLE, last_d=0.
- iBus alone reads 0x00001000 (ADR=0x400), slave ACKs at the 3rd cycle with DAT=0xDEADBEEF -> busWishbone_CYC rises 1 cycle after the request; iBusWishbone_ACK=1 with data 0xDEADBEEF; dBusWishbone_ACK stays 0; WE=0.
- iBus and dBus request in the same cycle after reset -> dBus granted first (write 0x12345678, SEL=0xF, WE=1). After its ACK, 1 idle cycle, then iBus granted.
- Continuous requests from both, slave always ACKs in 1 cycle -> grants alternate D,I,D,I over 8 transfers; no ACK is delivered to the wrong master.
- Granted dBus slave returns ERR -> dBusWishbone_ERR=1 for 1 cycle; grant released; pending iBus granted next.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never responds -> iBusWishbone_ERR pulses in the 4th granted cycle; busWishbone_CYC=0 in that cycle; a late ACK 2 cycles later is not forwarded.
